// File: rtl/freq_gate_counter_pkg.sv
// Shared types and defaults for the gated frequency counter.
// FSM encoding plus default gate length and result width.
package freq_gate_counter_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_t;

    // 1 s gate at 50 MHz
    localparam int GATE_CYCLES_DEF = 50_000_000;

    // Result width, matches the display data input
    localparam int CNT_W_DEF = 30;

    // Largest count representable at the default width
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

endpackage

// File: rtl/freq_gate_counter_sig_sync_edge.sv
// Brings the asynchronous test signal into sys_clk and
// flags each of its rising edges with a one-cycle pulse.
module sig_sync_edge
    import freq_gate_counter_pkg::*;
(
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic sig_in,
    output logic edge_p
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Two-flop synchronizer followed by one delay flop
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign edge_p = r_s2 & ~r_s3;

endmodule

// File: rtl/freq_gate_counter.sv
// Counts rising edges of sig_in over a fixed gate of sys_clk
// cycles and publishes the saturating result once per gate.
module freq_gate_counter
    import freq_gate_counter_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             sig_in,
    input  logic             enable,
    input  logic             cont,
    output logic [CNT_W-1:0] freq_data,
    output logic             freq_valid,
    output logic             ovf,
    output logic             busy
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0]    GATE_ONE  = GW'(1);
    localparam logic [CNT_W-1:0] CMAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_clr;
    logic             w_run;
    logic             w_latch;
    logic             w_edge_p;
    logic [GW-1:0]    r_gate_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_sat;
    logic [CNT_W-1:0] r_freq_data;
    logic             r_freq_valid;
    logic             r_ovf;

    sig_sync_edge u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .sig_in    (sig_in),
        .edge_p    (w_edge_p)
    );

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath controls; LATCH is the one dead cycle
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_run       = 1'b0;
        w_latch     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_nxt = GATE;
                    w_clr       = 1'b1;
                end
            end
            GATE: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_run = 1'b1;
                    if (r_gate_cnt == GATE_LAST) begin
                        w_state_nxt = LATCH;
                    end
                end
            end
            LATCH: begin
                w_latch = 1'b1;
                if (enable && cont) begin
                    w_state_nxt = GATE;
                    w_clr       = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Gate timer and saturating edge counter with sticky overflow
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
        end else if (w_clr) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
        end else if (w_run) begin
            r_gate_cnt <= r_gate_cnt + GATE_ONE;
            if (w_edge_p) begin
                if (r_edge_cnt == CMAX) begin
                    r_sat <= 1'b1;
                end else begin
                    r_edge_cnt <= r_edge_cnt + CNT_ONE;
                end
            end
        end
    end

    // Result registers, updated only when a gate completes
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_freq_data  <= '0;
            r_freq_valid <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_freq_valid <= w_latch;
            if (w_latch) begin
                r_freq_data <= r_edge_cnt;
                r_ovf       <= r_sat;
            end
        end
    end

    assign freq_data  = r_freq_data;
    assign freq_valid = r_freq_valid;
    assign ovf        = r_ovf;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed scoreboard bench for freq_gate_counter with a
// 1000-cycle gate; a second instance uses an 8-bit result.
module tb_freq_gate_counter;

    localparam int GC = 1000;

    typedef struct {
        int   lo;
        int   hi;
        logic ovf;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        sig_in;
    logic        enable;
    logic        cont;
    logic [29:0] freq_data;
    logic        freq_valid;
    logic        ovf;
    logic        busy;

    logic        sig_in2;
    logic        enable2;
    logic        cont2;
    logic [7:0]  freq_data2;
    logic        freq_valid2;
    logic        ovf2;
    logic        busy2;

    int   mode;
    logic sig_man;
    logic g2on;
    logic g2;
    logic g10;
    int   ph;

    int   n_tests;
    int   n_fail;
    int   cyc;
    int   v1_count;

    exp_t q1[$];
    exp_t q2[$];

    always #5 sys_clk = ~sys_clk;

    assign sig_in  = (mode == 1) ? g10 : ((mode == 2) ? g2 : sig_man);
    assign sig_in2 = g2on ? g2 : 1'b0;

    freq_gate_counter #(
        .GATE_CYCLES (GC),
        .CNT_W       (30)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .sig_in     (sig_in),
        .enable     (enable),
        .cont       (cont),
        .freq_data  (freq_data),
        .freq_valid (freq_valid),
        .ovf        (ovf),
        .busy       (busy)
    );

    freq_gate_counter #(
        .GATE_CYCLES (GC),
        .CNT_W       (8)
    ) dut8 (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .sig_in     (sig_in2),
        .enable     (enable2),
        .cont       (cont2),
        .freq_data  (freq_data2),
        .freq_valid (freq_valid2),
        .ovf        (ovf2),
        .busy       (busy2)
    );

    // Free-running period-2 and period-10 stimulus, off the clock edge
    initial begin
        ph  = 0;
        g2  = 1'b0;
        g10 = 1'b0;
        forever begin
            @(posedge sys_clk);
            #3;
            ph  = ph + 1;
            g2  = ph[0];
            g10 = ((ph % 10) < 5);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input int which);
        exp_t e;
        int   d;
        logic o;
        int   sz;
        d  = (which == 1) ? int'(freq_data) : int'(freq_data2);
        o  = (which == 1) ? ovf : ovf2;
        sz = (which == 1) ? q1.size() : q2.size();
        n_tests++;
        assert (sz > 0) else begin
            n_fail++;
            $error("FAIL unexpected_valid%0d: got data %0d want none",
                   which, d);
        end
        if (sz > 0) begin
            e = (which == 1) ? q1.pop_front() : q2.pop_front();
            n_tests++;
            assert (d >= e.lo && d <= e.hi) else begin
                n_fail++;
                $error("FAIL data%0d: got %0d want %0d..%0d",
                       which, d, e.lo, e.hi);
            end
            chk($sformatf("ovf%0d", which), 64'(o), 64'(e.ovf));
        end
    endtask

    // One clock cycle; outputs sampled on the falling edge
    task automatic tick();
        @(negedge sys_clk);
        cyc++;
        if (freq_valid) begin
            v1_count++;
            sb_pop(1);
        end
        if (freq_valid2) begin
            sb_pop(2);
        end
    endtask

    task automatic wait_valid(input int which, input int max,
                              output int n);
        logic v;
        n = 0;
        v = 1'b0;
        while (!v && n < max) begin
            tick();
            n++;
            v = (which == 1) ? freq_valid : freq_valid2;
        end
        chk($sformatf("valid%0d_seen", which), 64'(v), 64'(1));
    endtask

    initial begin
        int n;
        int t1;
        int t2;
        int t3;
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        v1_count  = 0;
        sys_rst_n = 1'b0;
        enable    = 1'b0;
        cont      = 1'b0;
        enable2   = 1'b0;
        cont2     = 1'b0;
        mode      = 0;
        sig_man   = 1'b0;
        g2on      = 1'b0;

        repeat (3) tick();
        chk("rst_data", 64'(freq_data), 64'(0));
        chk("rst_valid", 64'(freq_valid), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_data8", 64'(freq_data2), 64'(0));
        chk("rst_busy8", 64'(busy2), 64'(0));
        sys_rst_n = 1'b1;
        repeat (20) tick();

        // edge_p lands on the LATCH cycle: dropped
        q1.push_back('{0, 0, 1'b0});
        enable = 1'b1;
        repeat (GC - 1) tick();
        sig_man = 1'b1;
        wait_valid(1, 100, n);
        enable  = 1'b0;
        sig_man = 1'b0;
        repeat (20) tick();

        // edge_p lands on the last GATE cycle: counted
        q1.push_back('{1, 1, 1'b0});
        enable = 1'b1;
        repeat (GC - 2) tick();
        sig_man = 1'b1;
        wait_valid(1, 100, n);
        chk("last_cycle_lat", 64'(n), 64'(4));
        enable  = 1'b0;
        sig_man = 1'b0;
        repeat (20) tick();

        // Period-10 input, single shot
        mode = 1;
        repeat (20) tick();
        q1.push_back('{100, 100, 1'b0});
        enable = 1'b1;
        wait_valid(1, GC + 100, n);
        chk("single_lat", 64'(n), 64'(GC + 2));
        enable = 1'b0;
        tick();
        chk("valid_pulse", 64'(freq_valid), 64'(0));
        chk("data_hold", 64'(freq_data), 64'(100));
        tick();
        chk("busy_after", 64'(busy), 64'(0));
        repeat (20) tick();

        // Abort at gate cycle 500
        enable = 1'b1;
        repeat (500) tick();
        chk("abort_busy", 64'(busy), 64'(1));
        enable = 1'b0;
        tick();
        chk("abort_idle", 64'(busy), 64'(0));
        t1 = v1_count;
        repeat (GC + 100) tick();
        chk("abort_novalid", 64'(v1_count), 64'(t1));
        chk("abort_data", 64'(freq_data), 64'(100));
        chk("abort_ovf", 64'(ovf), 64'(0));

        // Reset pulse mid-gate, enable held
        enable = 1'b1;
        repeat (300) tick();
        n = 0;
        while (((ph + 1) % 10) < 5 && n < 20) begin
            tick();
            n++;
        end
        sys_rst_n = 1'b0;
        tick();
        chk("mrst_data", 64'(freq_data), 64'(0));
        chk("mrst_valid", 64'(freq_valid), 64'(0));
        chk("mrst_ovf", 64'(ovf), 64'(0));
        chk("mrst_busy", 64'(busy), 64'(0));
        sys_rst_n = 1'b1;
        q1.push_back('{100, 100, 1'b0});
        wait_valid(1, GC + 200, n);
        chk("mrst_lat", 64'(n), 64'(GC + 2));
        enable = 1'b0;
        repeat (20) tick();

        // Period-2 input, three back-to-back gates
        mode = 2;
        cont = 1'b1;
        repeat (20) tick();
        for (int i = 0; i < 3; i++) q1.push_back('{499, 500, 1'b0});
        enable = 1'b1;
        wait_valid(1, GC + 100, n);
        t1 = cyc;
        wait_valid(1, GC + 100, n);
        t2 = cyc;
        wait_valid(1, GC + 100, n);
        t3 = cyc;
        enable = 1'b0;
        cont   = 1'b0;
        chk("cont_gap1", 64'(t2 - t1), 64'(GC + 1));
        chk("cont_gap2", 64'(t3 - t2), 64'(GC + 1));
        repeat (5) tick();
        chk("cont_busy", 64'(busy), 64'(0));

        // 8-bit result: saturate, then an empty gate clears ovf
        g2on = 1'b1;
        repeat (20) tick();
        q2.push_back('{255, 255, 1'b1});
        q2.push_back('{0, 0, 1'b0});
        enable2 = 1'b1;
        cont2   = 1'b1;
        repeat (700) tick();
        g2on = 1'b0;
        wait_valid(2, 500, n);
        wait_valid(2, GC + 100, n);
        enable2 = 1'b0;
        cont2   = 1'b0;
        repeat (5) tick();
        chk("sat_busy", 64'(busy2), 64'(0));

        chk("q1_empty", 64'(q1.size()), 64'(0));
        chk("q2_empty", 64'(q2.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
